// File: rtl/dma_ctrl.sv
// Single-channel DMA controller for the MMU09 SBC: CPU register window, HALT/BA/BS
// bus handshake and a two-cycle read/write byte mover between the CH375 card and RAM.
module dma_ctrl #(
  parameter int ADDR_W = 19,
  parameter int CNT_W  = 9
) (
  input  logic              i_eclk,
  input  logic              i_reset_n,
  input  logic              i_cs_n,
  input  logic              i_rw,
  input  logic [2:0]        i_addr,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_data,
  output logic              o_halt_n,
  input  logic              i_ba,
  input  logic              i_bs,
  output logic              o_busmaster,
  output logic [ADDR_W-1:0] o_padr,
  output logic              o_ramcs_n,
  output logic              o_ram_rw,
  output logic [7:0]        o_ram_wdata,
  input  logic [7:0]        i_ram_rdata,
  output logic              o_dev_rd_n,
  output logic              o_dev_wr_n,
  input  logic              i_dev_ready,
  output logic [7:0]        o_dev_wdata,
  input  logic [7:0]        i_dev_rdata,
  output logic              o_irq_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER_RD,
    S_XFER_WR,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                dir_q;
  logic                ie_q;
  logic                done_q;
  logic                halt_n_q;
  logic                busmaster_q;
  logic [7:0]          byte_q;

  logic                busy;
  logic                reg_wr;
  logic                start_req;
  logic                status_rd;
  logic                rd_fire;
  logic                wr_fire;
  logic [CNT_W-1:0]    cnt_next;
  logic [23:0]         addr_pad;
  logic [15:0]         cnt_pad;
  logic [7:0]          status;

  assign busy      = (state_q == S_REQ) || (state_q == S_XFER_RD) || (state_q == S_XFER_WR);
  assign reg_wr    = !i_cs_n && !i_rw && !busy;
  assign start_req = reg_wr && (i_addr == 3'd5) && i_data[7];
  assign status_rd = !i_cs_n && i_rw && (i_addr == 3'd5);
  assign rd_fire   = (state_q == S_XFER_RD) && i_dev_ready;
  assign wr_fire   = (state_q == S_XFER_WR);
  assign cnt_next  = cnt_q - CNT_W'(1);
  assign addr_pad  = 24'(addr_q);
  assign cnt_pad   = 16'(cnt_q);
  assign status    = {busy, done_q, 4'b0000, ie_q, dir_q};

  // Register window, handshake FSM and address/count stepping share one clocked process
  // so that CPU writes (only legal when not busy) never race the transfer updates.
  always_ff @(negedge i_eclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      ie_q        <= 1'b0;
      done_q      <= 1'b0;
      halt_n_q    <= 1'b1;
      busmaster_q <= 1'b0;
    end else begin
      if (status_rd)
        done_q <= 1'b0;

      if (reg_wr) begin
        case (i_addr)
          3'd0: addr_q <= ADDR_W'({addr_pad[23:8], i_data});
          3'd1: addr_q <= ADDR_W'({addr_pad[23:16], i_data, addr_pad[7:0]});
          3'd2: addr_q <= ADDR_W'({5'b00000, i_data[2:0], addr_pad[15:0]});
          3'd3: cnt_q  <= CNT_W'({cnt_pad[15:8], i_data});
          3'd4: cnt_q  <= CNT_W'({7'b0000000, i_data[0], cnt_pad[7:0]});
          3'd5: begin
            dir_q <= i_data[0];
            ie_q  <= i_data[1];
          end
          default: ;
        endcase
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (start_req) begin
            // An empty block completes on the spot without touching the bus.
            if (cnt_q != '0) begin
              state_q  <= S_REQ;
              halt_n_q <= 1'b0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (i_ba && i_bs) begin
            state_q     <= S_XFER_RD;
            busmaster_q <= 1'b1;
          end
        end
        S_XFER_RD: begin
          if (i_dev_ready)
            state_q <= S_XFER_WR;
        end
        S_XFER_WR: begin
          addr_q <= addr_q + ADDR_W'(1);
          cnt_q  <= cnt_next;
          if (cnt_next == '0) begin
            state_q     <= S_DONE;
            halt_n_q    <= 1'b1;
            busmaster_q <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            state_q <= S_XFER_RD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(negedge i_eclk) begin
    if (rd_fire)
      byte_q <= dir_q ? i_ram_rdata : i_dev_rdata;
  end

  always_comb begin
    o_data = 8'h00;
    case (i_addr)
      3'd0: o_data = addr_pad[7:0];
      3'd1: o_data = addr_pad[15:8];
      3'd2: o_data = addr_pad[23:16];
      3'd3: o_data = cnt_pad[7:0];
      3'd4: o_data = cnt_pad[15:8];
      3'd5: o_data = status;
      default: o_data = 8'h00;
    endcase
  end

  // Strobes decode from the registered state; the read strobe also waits on device ready.
  assign o_dev_rd_n  = !(rd_fire && !dir_q);
  assign o_dev_wr_n  = !(wr_fire && dir_q);
  assign o_ramcs_n   = !((rd_fire && dir_q) || (wr_fire && !dir_q));
  assign o_ram_rw    = !(wr_fire && !dir_q);
  assign o_ram_wdata = byte_q;
  assign o_dev_wdata = byte_q;
  assign o_padr      = addr_q;
  assign o_halt_n    = halt_n_q;
  assign o_busmaster = busmaster_q;
  assign o_irq_n     = !(done_q && ie_q);

endmodule

// File: tb/tb_dma_ctrl.sv
// Testbench for dma_ctrl: directed and random block transfers against a RAM/device
// model, with a scoreboard queue of expected sink writes popped by a bus monitor.
module tb_dma_ctrl;

  logic        i_eclk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_cs_n = 1'b1;
  logic        i_rw = 1'b1;
  logic [2:0]  i_addr = 3'd0;
  logic [7:0]  i_data = 8'h00;
  logic [7:0]  o_data;
  logic        o_halt_n;
  logic        i_ba = 1'b0;
  logic        i_bs = 1'b0;
  logic        o_busmaster;
  logic [18:0] o_padr;
  logic        o_ramcs_n;
  logic        o_ram_rw;
  logic [7:0]  o_ram_wdata;
  logic [7:0]  i_ram_rdata;
  logic        o_dev_rd_n;
  logic        o_dev_wr_n;
  logic        i_dev_ready = 1'b1;
  logic [7:0]  o_dev_wdata;
  logic [7:0]  i_dev_rdata;
  logic        o_irq_n;

  dma_ctrl #(.ADDR_W(19), .CNT_W(9)) dut (
    .i_eclk(i_eclk), .i_reset_n(i_reset_n), .i_cs_n(i_cs_n), .i_rw(i_rw),
    .i_addr(i_addr), .i_data(i_data), .o_data(o_data), .o_halt_n(o_halt_n),
    .i_ba(i_ba), .i_bs(i_bs), .o_busmaster(o_busmaster), .o_padr(o_padr),
    .o_ramcs_n(o_ramcs_n), .o_ram_rw(o_ram_rw), .o_ram_wdata(o_ram_wdata),
    .i_ram_rdata(i_ram_rdata), .o_dev_rd_n(o_dev_rd_n), .o_dev_wr_n(o_dev_wr_n),
    .i_dev_ready(i_dev_ready), .o_dev_wdata(o_dev_wdata), .i_dev_rdata(i_dev_rdata),
    .o_irq_n(o_irq_n)
  );

  typedef struct packed {
    logic        is_dev;
    logic [18:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] mem [0:524287];
  logic [7:0] dev_src [0:1023];
  int         dev_idx = 0;
  bit         dev_rd_seen = 1'b0;
  int         src_cnt = 0;
  int         cyc = 0;
  int         grant_cyc = -1000;
  int         end_cyc = 0;
  int         grant_delay = 0;
  bit         stall_mode = 1'b0;
  bit         rnd_ready = 1'b0;
  bit         halt_low_seen = 1'b0;
  logic       prev_halt = 1'b1;
  int         n_chk = 0;
  int         n_fail = 0;

  assign i_ram_rdata = mem[o_padr];
  assign i_dev_rdata = dev_src[dev_idx[9:0]];

  initial forever #5 i_eclk = ~i_eclk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle counter and grant-edge timestamp (DUT outputs still hold pre-edge values here).
  initial forever begin
    @(negedge i_eclk);
    cyc++;
    if (i_reset_n && !o_halt_n && i_ba && i_bs && !o_busmaster)
      grant_cyc = cyc;
  end

  // CPU side of the bus handshake: BA follows HALT, BS lags by grant_delay cycles.
  initial begin : grant_drv
    int gcnt;
    gcnt = 0;
    forever begin
      @(negedge i_eclk);
      #1;
      if (!o_halt_n) begin
        i_ba = 1'b1;
        i_bs = (gcnt >= grant_delay);
        gcnt++;
      end else begin
        i_ba = 1'b0;
        i_bs = 1'b0;
        gcnt = 0;
      end
    end
  end

  initial begin : ready_drv
    int rel;
    forever begin
      @(negedge i_eclk);
      #1;
      rel = cyc - grant_cyc;
      if (rnd_ready)
        i_dev_ready = ($urandom_range(3) != 0);
      else
        i_dev_ready = !(stall_mode && (rel == 2 || rel == 3));
    end
  end

  initial forever begin
    @(negedge i_eclk);
    #1;
    if (dev_rd_seen) begin
      dev_idx++;
      dev_rd_seen = 1'b0;
    end
  end

  // Monitor: bus ownership sanity, source strobe counting and scoreboard pops on sink writes.
  initial forever begin
    ev_t got;
    ev_t e;
    @(posedge i_eclk);
    if (!o_halt_n) halt_low_seen = 1'b1;
    if (!prev_halt && o_halt_n) end_cyc = cyc;
    prev_halt = o_halt_n;
    if (o_busmaster || !o_ramcs_n || !o_dev_rd_n || !o_dev_wr_n)
      check("bus_owned", 32'({i_ba, i_bs, o_busmaster, o_halt_n}), 32'h0000000E);
    if (!o_dev_rd_n) begin
      dev_rd_seen = 1'b1;
      src_cnt++;
    end
    if (!o_ramcs_n && o_ram_rw) src_cnt++;
    if ((!o_ramcs_n && !o_ram_rw) || !o_dev_wr_n) begin
      if (!o_dev_wr_n) got = '{is_dev: 1'b1, addr: 19'd0, data: o_dev_wdata};
      else begin
        got = '{is_dev: 1'b0, addr: o_padr, data: o_ram_wdata};
        mem[o_padr] = o_ram_wdata;
      end
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sink_unexpected: got write 0x%0h with no expected entry", got);
      end else begin
        e = exp_q.pop_front();
        check("sink_write", 32'(got), 32'(e));
      end
    end
  end

  task automatic sync();
    @(negedge i_eclk);
    #1;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    i_cs_n = 1'b0; i_rw = 1'b0; i_addr = a; i_data = d;
    @(negedge i_eclk);
    #1;
    i_cs_n = 1'b1; i_rw = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
    i_cs_n = 1'b0; i_rw = 1'b1; i_addr = a;
    @(posedge i_eclk);
    d = o_data;
    @(negedge i_eclk);
    #1;
    i_cs_n = 1'b1;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    cpu_read(a, d);
    check(name, 32'(d), 32'(exp));
  endtask

  // Reference: byte i of the block goes to/from (ADDR + i) mod 512K, in source order.
  task automatic setup_xfer(input bit dir, input logic [18:0] a, input int n,
                            input bit ie, input bit fixed);
    logic [18:0] ai;
    logic [8:0]  nn;
    nn = 9'(n);
    for (int i = 0; i < n; i++) begin
      ai = a + 19'(i);
      if (!dir) begin
        if (!fixed) dev_src[i] = 8'($urandom);
        exp_q.push_back('{is_dev: 1'b0, addr: ai, data: dev_src[i]});
      end else begin
        mem[ai] = 8'($urandom);
        exp_q.push_back('{is_dev: 1'b1, addr: 19'd0, data: mem[ai]});
      end
    end
    dev_idx = 0;
    src_cnt = 0;
    grant_cyc = -1000;
    halt_low_seen = 1'b0;
    cpu_write(3'd0, a[7:0]);
    cpu_write(3'd1, a[15:8]);
    cpu_write(3'd2, {5'b00000, a[18:16]});
    cpu_write(3'd3, nn[7:0]);
    cpu_write(3'd4, {7'b0000000, nn[8]});
    cpu_write(3'd5, {1'b1, 5'b00000, ie, dir});
  endtask

  task automatic finish_xfer(input bit dir, input logic [18:0] a, input int n,
                             input bit ie, input int exp_cycles);
    int t;
    logic [18:0] fa;
    fa = a + 19'(n);
    check("halt_after_start", 32'(o_halt_n), 32'd0);
    t = 0;
    while (o_halt_n !== 1'b1 && t < 3000) begin
      @(posedge i_eclk);
      t++;
    end
    sync();
    check("xfer_completed", 32'(t < 3000), 32'd1);
    if (exp_cycles >= 0)
      check("xfer_cycles", 32'(end_cyc - grant_cyc), 32'(exp_cycles));
    check("src_strobes", 32'(src_cnt), 32'(n));
    check("sink_pending", 32'(exp_q.size()), 32'd0);
    check("irq_at_done", 32'(o_irq_n), 32'(!ie));
    read_check("addr_lo", 3'd0, fa[7:0]);
    read_check("addr_mid", 3'd1, fa[15:8]);
    read_check("addr_hi", 3'd2, {5'b00000, fa[18:16]});
    read_check("count_lo", 3'd3, 8'h00);
    read_check("count_hi", 3'd4, 8'h00);
    read_check("status_done", 3'd5, {2'b01, 4'b0000, ie, dir});
    check("irq_after_read", 32'(o_irq_n), 32'd1);
    exp_q.delete();
  endtask

  initial begin
    int t;
    repeat (3) @(negedge i_eclk);
    #1;
    check("rst_halt_n", 32'(o_halt_n), 32'd1);
    check("rst_busmaster", 32'(o_busmaster), 32'd0);
    check("rst_ram_strobes", 32'({o_ramcs_n, o_ram_rw}), 32'd3);
    check("rst_dev_strobes", 32'({o_dev_rd_n, o_dev_wr_n}), 32'd3);
    check("rst_irq_n", 32'(o_irq_n), 32'd1);
    check("rst_padr", 32'(o_padr), 32'd0);
    i_reset_n = 1'b1;
    sync();
    for (int r = 0; r < 8; r++) read_check("rst_reg", 3'(r), 8'h00);

    // Device to RAM, fixed bytes A1..A4
    for (int i = 0; i < 4; i++) dev_src[i] = 8'hA1 + 8'(i);
    setup_xfer(1'b0, 19'h12340, 4, 1'b0, 1'b1);
    finish_xfer(1'b0, 19'h12340, 4, 1'b0, 8);
    for (int i = 0; i < 4; i++)
      check("ram_content", 32'(mem[19'h12340 + 19'(i)]), 32'(8'hA1 + 8'(i)));

    // RAM to device with two ready-low cycles before byte 2
    stall_mode = 1'b1;
    setup_xfer(1'b1, 19'h05000, 3, 1'b0, 1'b0);
    finish_xfer(1'b1, 19'h05000, 3, 1'b0, 8);
    stall_mode = 1'b0;

    // BS withheld for 5 cycles after START
    grant_delay = 5;
    setup_xfer(1'b0, 19'h00200, 2, 1'b0, 1'b0);
    finish_xfer(1'b0, 19'h00200, 2, 1'b0, 4);
    grant_delay = 0;

    // Completion interrupt
    setup_xfer(1'b0, 19'h3FF00, 3, 1'b1, 1'b0);
    finish_xfer(1'b0, 19'h3FF00, 3, 1'b1, 6);

    // COUNT=0 START completes without a bus request
    setup_xfer(1'b0, 19'h01234, 0, 1'b0, 1'b0);
    check("zero_no_halt", 32'(o_halt_n), 32'd1);
    repeat (4) sync();
    check("zero_halt_never_low", 32'(halt_low_seen), 32'd0);
    read_check("zero_status", 3'd5, 8'h40);
    read_check("zero_status_cleared", 3'd5, 8'h00);

    // Address wrap at the top of physical RAM
    setup_xfer(1'b0, 19'h7FFFF, 2, 1'b0, 1'b0);
    finish_xfer(1'b0, 19'h7FFFF, 2, 1'b0, 4);

    // Register writes during BUSY are ignored
    grant_delay = 6;
    setup_xfer(1'b1, 19'h0ABCD, 3, 1'b0, 1'b0);
    cpu_write(3'd0, 8'h55);
    cpu_write(3'd3, 8'h01);
    read_check("status_busy", 3'd5, 8'h81);
    finish_xfer(1'b1, 19'h0ABCD, 3, 1'b0, 6);
    grant_delay = 0;

    // Reset asserted mid-block
    setup_xfer(1'b0, 19'h00100, 10, 1'b1, 1'b0);
    t = 0;
    while (!o_busmaster && t < 100) begin
      @(posedge i_eclk);
      t++;
    end
    check("mid_reset_got_bus", 32'(o_busmaster), 32'd1);
    repeat (3) @(posedge i_eclk);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("mid_reset_halt_n", 32'(o_halt_n), 32'd1);
    check("mid_reset_busmaster", 32'(o_busmaster), 32'd0);
    check("mid_reset_ram", 32'({o_ramcs_n, o_ram_rw}), 32'd3);
    check("mid_reset_dev", 32'({o_dev_rd_n, o_dev_wr_n}), 32'd3);
    check("mid_reset_irq", 32'(o_irq_n), 32'd1);
    check("mid_reset_padr", 32'(o_padr), 32'd0);
    sync();
    exp_q.delete();
    dev_rd_seen = 1'b0;
    i_reset_n = 1'b1;
    sync();
    read_check("post_reset_addr", 3'd0, 8'h00);
    read_check("post_reset_count", 3'd3, 8'h00);
    read_check("post_reset_status", 3'd5, 8'h00);

    // Randomized blocks with random device-ready stalls
    rnd_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      bit d;
      bit ie;
      logic [18:0] a;
      int n;
      d = 1'($urandom_range(1));
      ie = 1'($urandom_range(1));
      a = 19'($urandom);
      n = int'($urandom_range(16, 1));
      grant_delay = int'($urandom_range(3));
      setup_xfer(d, a, n, ie, 1'b0);
      finish_xfer(d, a, n, ie, -1);
    end
    rnd_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_ctrl.md
# dma_ctrl

Single-channel DMA controller for the MMU09 SBC. It moves blocks of up to 511 bytes between the CH375 storage card and the 512K physical RAM without CPU involvement. It takes the 6809 off the bus with HALT, drives the 19-bit physical RAM address directly, and releases the bus when the block is done. The CPU programs it through a small register window selected by the address decoder, and it raises an optional completion interrupt.

## Interface
Parameters:
- ADDR_W, 19: physical RAM address width.
- CNT_W, 9: transfer count width (max 511 bytes).

Ports:
- i_eclk  in  1  block clock; all flops update on the falling edge (end of the 6809 bus cycle).
- i_reset_n  in  1  asynchronous, active-low reset.
- i_cs_n  in  1  register-window select from the decoder.
- i_rw  in  1  CPU R/W (1 = read).
- i_addr  in  3  register index (vadr[2:0]).
- i_data  in  8  CPU write data.
- o_data  out  8  register read data (combinational).
- o_halt_n  out  1  to CPU HALT.
- i_ba, i_bs  in  1 each  CPU bus status; BA=1 and BS=1 means the bus is granted.
- o_busmaster  out  1  high while DMA owns the bus; the SBC muxes o_padr onto RAM.
- o_padr  out  ADDR_W  RAM address.
- o_ramcs_n, o_ram_rw  out  1 each  RAM select and direction (1 = read).
- o_ram_wdata, i_ram_rdata  out/in  8  RAM data.
- o_dev_rd_n, o_dev_wr_n  out  1 each  CH375 strobes, one cycle wide.
- i_dev_ready  in  1  device can source or sink a byte.
- o_dev_wdata, i_dev_rdata  out/in  8  device data.
- o_irq_n  out  1  completion interrupt, active-low level.

## Operation
- Registers (write when i_cs_n=0, i_rw=0):
  - 0, 1, 2: ADDR[7:0], ADDR[15:8], ADDR[18:16] (bits 2:0 of reg 2).
  - 3, 4: COUNT[7:0], COUNT[8] (bit 0 of reg 4).
  - 5: CTRL. bit0 DIR (0 = device to RAM, 1 = RAM to device), bit1 IE, bit7 START.
- Reads of 0–4 return the live address and remaining count; unused bits read 0.
- Reading reg 5 returns STATUS: bit7 BUSY, bit6 DONE, bit1 IE, bit0 DIR. The read clears DONE.
- Indices 6 and 7 read 0; writes to them are ignored.
- Any register write while BUSY is ignored.
- START with COUNT=0: no bus request; DONE sets immediately.
- State machine:
  - IDLE → REQ on START with COUNT≠0.
  - REQ: o_halt_n=0. Go to XFER_RD when i_ba=1 and i_bs=1 in the same sample.
  - XFER_RD: if i_dev_ready=0, stay (wait). Otherwise assert the source strobe for one cycle and latch the byte:
    - DIR=0: o_dev_rd_n=0, latch i_dev_rdata.
    - DIR=1: o_ramcs_n=0, o_ram_rw=1, latch i_ram_rdata.
  - XFER_WR: assert the destination strobe for one cycle with the latched byte:
    - DIR=0: o_ramcs_n=0, o_ram_rw=0.
    - DIR=1: o_dev_wr_n=0.
    - Then ADDR += 1 (wraps 0x7FFFF → 0x00000) and COUNT −= 1.
    - If the new COUNT = 0, go to DONE; otherwise go to XFER_RD.
  - DONE: o_halt_n=1, o_busmaster=0, BUSY=0, DONE=1. Go to IDLE next cycle.
- o_busmaster = 1 in XFER_RD and XFER_WR only.
- o_irq_n = !(DONE & IE).
- DONE set and a STATUS read in the same cycle: set wins.

## Timing
- Reset values:
  - o_halt_n=1, o_busmaster=0, o_ramcs_n=1, o_ram_rw=1, o_dev_rd_n=1, o_dev_wr_n=1, o_irq_n=1.
  - o_padr=0, all registers 0, state IDLE.
- Reset asserted mid-transfer aborts immediately. The bus is released asynchronously and the remaining bytes are lost.
- START edge → o_halt_n low on the same edge. The first strobe comes 1 cycle after the grant is sampled.
- Throughput is 2 cycles per byte when i_dev_ready stays high. Each cycle of i_dev_ready=0 in XFER_RD adds one cycle.
- o_padr is stable across each XFER_RD/XFER_WR pair and changes only at the end of XFER_WR.
- A transfer of N bytes after grant takes 2N cycles plus stalls. DONE follows 1 cycle later.

## Test plan
- Device to RAM:
  - Setup: ADDR=0x12340, COUNT=4, device bytes A1 A2 A3 A4.
  - Expect: RAM[0x12340..43] = A1..A4, 8 cycles after grant; final ADDR=0x12344, COUNT=0; o_halt_n returns high.
- RAM to device with stalls:
  - Setup: COUNT=3, i_dev_ready low for 2 cycles before byte 2.
  - Expect: 3 o_dev_wr_n pulses, correct data, total 8 cycles after grant.
- Grant handshake: hold i_bs=0 for 5 cycles after START. Expect no strobes and o_busmaster=0 until BA=BS=1 is sampled.
- Completion and interrupt:
  - Setup: IE=1.
  - Expect: o_irq_n low after DONE; STATUS read returns 0x42 (DONE, IE, DIR=0) and o_irq_n high next cycle.
  - COUNT=0 START: DONE without o_halt_n ever going low.
- Wrap, busy lockout and reset:
  - Setup: ADDR=0x7FFFF, COUNT=2.
  - Expect: writes land at 0x7FFFF then 0x00000.
  - A register write during BUSY leaves ADDR unchanged.
  - i_reset_n low mid-block forces all outputs to reset values immediately.
